// File: rtl/tx_skip_inserter.sv
// tx_skip_inserter: transmit-side clock-compensation symbol inserter.
// Forwards {k, data[7:0]} symbols, fills empty data slots with IDLE_SYMBOL, and
// after every SKIP_INTERVAL data slots emits a burst of SKIP_LEN SKIP_SYMBOLs.
// Optional feature macro: TX_SKIP_FORCE_EN adds i_skip_force, which requests a
// skip burst immediately after the current data slot.
module tx_skip_inserter #(
    parameter int          SKIP_INTERVAL = 1024,
    parameter int          SKIP_LEN      = 2,
    parameter logic [8:0]  SKIP_SYMBOL   = 9'h17C,
    parameter logic [8:0]  IDLE_SYMBOL   = 9'h1BC
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [8:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [8:0] o_data,
    output logic       o_skip_active
`ifdef TX_SKIP_FORCE_EN
    ,
    input  logic       i_skip_force
`endif
);

    localparam int IW = $clog2(SKIP_INTERVAL);
    localparam int SW = $clog2(SKIP_LEN) + 1;

    localparam logic [IW-1:0] INTERVAL_LAST = IW'(SKIP_INTERVAL - 1);
    localparam logic [SW-1:0] SKIP_LAST     = SW'(SKIP_LEN - 1);

    localparam logic [0:0] S_DATA = 1'b0;
    localparam logic [0:0] S_SKIP = 1'b1;

    logic [0:0]    r_state;
    logic [IW-1:0] r_interval_cnt;
    logic [SW-1:0] r_skip_cnt;
    logic          w_force;
    logic          w_window_end;

`ifdef TX_SKIP_FORCE_EN
    assign w_force = i_skip_force;
`else
    assign w_force = 1'b0;
`endif

    // A forced request and a terminal count collapse into the same single burst.
    assign w_window_end = (r_interval_cnt == INTERVAL_LAST) || w_force;

    // Ready depends only on state and reset, never on i_valid.
    assign o_ready = (r_state == S_DATA) && !i_rst;

    // Slot sequencer: data slots counted free-running, then a fixed-length skip burst.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_DATA;
            r_interval_cnt <= '0;
            r_skip_cnt     <= '0;
            o_data         <= IDLE_SYMBOL;
            o_skip_active  <= 1'b0;
        end else begin
            case (r_state)
                S_DATA: begin
                    o_data        <= i_valid ? i_data : IDLE_SYMBOL;
                    o_skip_active <= 1'b0;
                    if (w_window_end) begin
                        r_interval_cnt <= '0;
                        r_state        <= S_SKIP;
                    end else begin
                        r_interval_cnt <= r_interval_cnt + 1'b1;
                    end
                end
                default: begin
                    o_data        <= SKIP_SYMBOL;
                    o_skip_active <= 1'b1;
                    if (r_skip_cnt == SKIP_LAST) begin
                        r_skip_cnt <= '0;
                        r_state    <= S_DATA;
                    end else begin
                        r_skip_cnt <= r_skip_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_skip_inserter.sv
// tb_tx_skip_inserter: scoreboard bench for tx_skip_inserter (SKIP_INTERVAL=8,
// SKIP_LEN=2). The reference model tracks the position inside the repeating
// window of data slots followed by skip slots; the driver pushes the expected
// output for each cycle and an independent monitor pops and compares it.
// Define TX_SKIP_FORCE_EN to also exercise i_skip_force.
module tb_tx_skip_inserter;

    localparam int         INTV = 8;
    localparam int         SLEN = 2;
    localparam logic [8:0] SKIP = 9'h17C;
    localparam logic [8:0] IDLE = 9'h1BC;
`ifdef TX_SKIP_FORCE_EN
    localparam bit FORCE_ON = 1'b1;
`else
    localparam bit FORCE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       r_rst = 1'b1;
    logic [8:0] r_data = '0;
    logic       r_valid = 1'b0;
    logic       r_force = 1'b0;
    logic       w_ready;
    logic [8:0] w_odata;
    logic       w_oskip;

    int n_checks = 0;
    int n_fail   = 0;
    int m_phase  = 0;
    bit started  = 1'b0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    tx_skip_inserter #(
        .SKIP_INTERVAL(INTV),
        .SKIP_LEN     (SLEN),
        .SKIP_SYMBOL  (SKIP),
        .IDLE_SYMBOL  (IDLE)
    ) dut (
        .i_clk        (clk),
        .i_rst        (r_rst),
        .i_data       (r_data),
        .i_valid      (r_valid),
        .o_ready      (w_ready),
        .o_data       (w_odata),
        .o_skip_active(w_oskip)
`ifdef TX_SKIP_FORCE_EN
        ,
        .i_skip_force (r_force)
`endif
    );

    // One stimulus cycle: drive inputs, predict from the window model, check ready.
    task automatic do_cycle(input logic rst, input logic vld, input logic [8:0] dat,
                            input logic frc, output logic acc);
        logic       exp_rdy;
        logic [8:0] exp_d;
        logic       exp_a;
        @(negedge clk);
        r_rst = rst; r_valid = vld; r_data = dat; r_force = frc;
        #1;
        if (rst) begin
            exp_rdy = 1'b0; exp_d = IDLE; exp_a = 1'b0;
            m_phase = 0;
        end else if (m_phase < INTV) begin
            exp_rdy = 1'b1; exp_d = vld ? dat : IDLE; exp_a = 1'b0;
            if (FORCE_ON && frc) m_phase = INTV;
            else                 m_phase = m_phase + 1;
        end else begin
            exp_rdy = 1'b0; exp_d = SKIP; exp_a = 1'b1;
            m_phase = m_phase + 1;
            if (m_phase == INTV + SLEN) m_phase = 0;
        end
        acc = vld && exp_rdy;
        n_checks++;
        if (w_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL ready t=%0t got=%b want=%b", $time, w_ready, exp_rdy);
        end
        exp_q.push_back({exp_a, exp_d});
        started = 1'b1;
    endtask

    // Idle-drive until the model's upcoming slot position equals target.
    task automatic run_to_phase(input int target);
        logic acc;
        int   i;
        i = 0;
        while (m_phase != target && i < 40) begin
            do_cycle(1'b0, 1'b0, 9'h000, 1'b0, acc);
            i++;
        end
        n_checks++;
        if (m_phase != target) begin
            n_fail++;
            $display("FAIL phase_wait got=%0d want=%0d", m_phase, target);
        end
    endtask

    // Monitor: every clock the DUT presents one registered output symbol.
    always @(posedge clk) begin
        logic [9:0] e;
        #1;
        if (started) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty t=%0t got=%h", $time, w_odata);
            end else begin
                e = exp_q.pop_front();
                if (w_odata !== e[8:0] || w_oskip !== e[9]) begin
                    n_fail++;
                    $display("FAIL output t=%0t got data=%h skip=%b want data=%h skip=%b",
                             $time, w_odata, w_oskip, e[8:0], e[9]);
                end
            end
        end
    end

    initial begin
        logic       acc;
        logic       hv;
        logic [8:0] hd;
        logic [8:0] seq;
        int         k;

        // Reset held with valid input present.
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b1, 9'h055, 1'b0, acc);

        // Continuous valid stream with incrementing payload, held when not accepted.
        seq = 9'h000;
        for (int i = 0; i < 30; i++) begin
            do_cycle(1'b0, 1'b1, seq, 1'b0, acc);
            if (acc) seq = seq + 9'h001;
        end

        // No input: idle fill with free-running skip cadence.
        for (int i = 0; i < 20; i++) do_cycle(1'b0, 1'b0, 9'h000, 1'b0, acc);

        // Reset during the first skip symbol of a burst.
        run_to_phase(INTV);
        do_cycle(1'b0, 1'b0, 9'h000, 1'b0, acc);
        do_cycle(1'b1, 1'b0, 9'h000, 1'b0, acc);
        for (int i = 0; i < 12; i++) do_cycle(1'b0, 1'b1, 9'h033, 1'b0, acc);

        // Forced burst mid-window, then a force pulse inside a burst.
        if (FORCE_ON) begin
            run_to_phase(3);
            do_cycle(1'b0, 1'b1, 9'h011, 1'b1, acc);
            for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, 9'h000, 1'b0, acc);
            run_to_phase(INTV);
            do_cycle(1'b0, 1'b0, 9'h000, 1'b1, acc);
            for (int i = 0; i < 12; i++) do_cycle(1'b0, 1'b0, 9'h000, 1'b0, acc);
        end

        // Back-pressure: 0AA offered across a burst is delivered once.
        run_to_phase(INTV);
        acc = 1'b0;
        k = 0;
        while (!acc && k < 10) begin
            do_cycle(1'b0, 1'b1, 9'h0AA, 1'b0, acc);
            k++;
        end
        n_checks++;
        if (k != SLEN + 1) begin
            n_fail++;
            $display("FAIL backpressure_accept_cycle got=%0d want=%0d", k, SLEN + 1);
        end
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, 9'h000, 1'b0, acc);

        // Randomized traffic with upstream hold semantics, forces and rare resets.
        hv = 1'b0; hd = '0;
        for (int i = 0; i < 400; i++) begin
            logic rst_r, frc_r;
            if (!hv) begin
                hv = ($urandom_range(0, 1) == 1);
                hd = 9'($urandom_range(0, 511));
            end
            rst_r = ($urandom_range(0, 99) == 0);
            frc_r = ($urandom_range(0, 15) == 0);
            do_cycle(rst_r, hv, hd, frc_r, acc);
            if (acc || rst_r) hv = 1'b0;
        end

        do_cycle(1'b0, 1'b0, 9'h000, 1'b0, acc);
        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
